nasti_uart_printer: RTL

Byte-stream-to-UART bridge that drives the 8-bit NASTI-lite register port of `osd_dem_uart_nasti` from upstream. After reset it programs the 16550-style divisor and line-control registers, then accepts characters on a valid/ready byte stream and writes each one to THR (offset 0). With polling enabled, it first waits until LSR.THRE is set. It is the on-chip producer that stands in front of the UART device-emulation module in place of a hard-coded stimulus sequence.

---
 rtl/nasti_uart_printer.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/nasti_uart_printer.sv
// nasti_uart_printer: byte stream to 16550-style UART register writes over an
// 8-bit NASTI-lite port. Programs DLL/DLM/LCR after reset, then writes each
// accepted byte to THR.
// Optional build macro NASTI_UART_PRINTER_POLL_EN: poll LSR.THRE before each
// character write, with POLL_LIMIT reads allowed per character.
module nasti_uart_printer #(
  parameter logic [15:0] DIVISOR    = 16'hdead,
  parameter logic [7:0]  LCR_VALUE  = 8'h03,
  parameter logic [15:0] POLL_LIMIT = 16'hffff
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  char_data,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [2:0]  aw_addr,
  output logic        aw_valid,
  input  logic        aw_ready,
  output logic [7:0]  w_data,
  output logic        w_valid,
  input  logic        w_ready,
  input  logic [1:0]  b_resp,
  input  logic        b_valid,
  output logic        b_ready,
  output logic [2:0]  ar_addr,
  output logic        ar_valid,
  input  logic        ar_ready,
  input  logic [7:0]  r_data,
  input  logic [1:0]  r_resp,
  input  logic        r_valid,
  output logic        r_ready,
  output logic        busy,
  output logic        err,
  output logic [15:0] tx_count
);

  typedef enum logic [3:0] {
    INIT_DLAB, INIT_DLL, INIT_DLM, INIT_LCR, IDLE, POLL_AR, POLL_R, WRITE, WAIT_B
  } state_t;

  state_t      state, state_n, src, src_n;
  logic        aw_valid_n, w_valid_n, aw_done, aw_done_n, w_done, w_done_n;
  logic        aw_fin, w_fin, err_n;
  logic [2:0]  aw_addr_n;
  logic [7:0]  w_data_n, hold, hold_n;
  logic [15:0] tx_count_n;
  logic        unused_rd;

  // States that drive a write-address/write-data pair
  function automatic logic is_wr(input state_t s);
    return (s == INIT_DLAB) || (s == INIT_DLL) || (s == INIT_DLM) ||
           (s == INIT_LCR) || (s == WRITE);
  endfunction

  function automatic logic [2:0] wr_addr(input state_t s);
    case (s)
      INIT_DLAB: return 3'd3;
      INIT_DLL:  return 3'd0;
      INIT_DLM:  return 3'd1;
      INIT_LCR:  return 3'd3;
      default:   return 3'd0;
    endcase
  endfunction

  function automatic logic [7:0] wr_data(input state_t s, input logic [7:0] b);
    case (s)
      INIT_DLAB: return 8'h80;
      INIT_DLL:  return DIVISOR[7:0];
      INIT_DLM:  return DIVISOR[15:8];
      INIT_LCR:  return LCR_VALUE & 8'h7f;
      default:   return b;
    endcase
  endfunction

  // Where a completed write response leads
  function automatic state_t succ(input state_t s);
    case (s)
      INIT_DLAB: return INIT_DLL;
      INIT_DLL:  return INIT_DLM;
      INIT_DLM:  return INIT_LCR;
      default:   return IDLE;
    endcase
  endfunction

`ifdef NASTI_UART_PRINTER_POLL_EN
  logic        ar_valid_n;
  logic [15:0] poll_cnt, poll_cnt_n;
`else
  assign ar_valid = 1'b0;
`endif

  assign char_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign b_ready    = 1'b1;
  assign r_ready    = 1'b1;
  assign unused_rd  = ^{r_data, r_resp, r_valid, ar_ready, POLL_LIMIT};

  // Next-state, handshake tracking and register next values
  always_comb begin
    state_n    = state;
    src_n      = src;
    aw_valid_n = aw_valid;
    w_valid_n  = w_valid;
    aw_done_n  = aw_done;
    w_done_n   = w_done;
    aw_addr_n  = aw_addr;
    w_data_n   = w_data;
    hold_n     = hold;
    err_n      = err;
    tx_count_n = tx_count;
    aw_fin     = aw_done | (aw_valid & aw_ready);
    w_fin      = w_done | (w_valid & w_ready);
`ifdef NASTI_UART_PRINTER_POLL_EN
    ar_valid_n = ar_valid;
    poll_cnt_n = poll_cnt;
`endif
    case (state)
      INIT_DLAB, INIT_DLL, INIT_DLM, INIT_LCR, WRITE: begin
        // Each channel drops the cycle after its own handshake; leave once both are done.
        aw_valid_n = ~aw_fin;
        w_valid_n  = ~w_fin;
        aw_done_n  = aw_fin;
        w_done_n   = w_fin;
        aw_addr_n  = wr_addr(state);
        w_data_n   = wr_data(state, hold);
        if (aw_fin && w_fin) begin
          state_n   = WAIT_B;
          src_n     = state;
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
        end
      end
      IDLE: begin
        if (char_valid) begin
          hold_n = char_data;
`ifdef NASTI_UART_PRINTER_POLL_EN
          state_n    = POLL_AR;
          ar_valid_n = 1'b1;
          poll_cnt_n = '0;
`else
          state_n = WRITE;
`endif
        end
      end
`ifdef NASTI_UART_PRINTER_POLL_EN
      POLL_AR: begin
        if (ar_valid && ar_ready) begin
          ar_valid_n = 1'b0;
          state_n    = POLL_R;
        end
      end
      POLL_R: begin
        if (r_valid) begin
          if (r_resp != 2'b00) err_n = 1'b1;
          if (r_data[5]) begin
            state_n = WRITE;
          end else if (({1'b0, poll_cnt} + 17'd1) >= {1'b0, POLL_LIMIT}) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end else begin
            poll_cnt_n = poll_cnt + 16'd1;
            ar_valid_n = 1'b1;
            state_n    = POLL_AR;
          end
        end
      end
`endif
      WAIT_B: begin
        if (b_valid) begin
          if (b_resp != 2'b00) err_n = 1'b1;
          if (src == WRITE) tx_count_n = tx_count + 16'd1;
          state_n = succ(src);
        end
      end
      default: state_n = INIT_DLAB;
    endcase
    // Raise both write valids on the entering edge so a write phase costs no idle cycle.
    if (is_wr(state_n) && !is_wr(state)) begin
      aw_valid_n = 1'b1;
      w_valid_n  = 1'b1;
      aw_addr_n  = wr_addr(state_n);
      w_data_n   = wr_data(state_n, hold_n);
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT_DLAB;
      src      <= INIT_DLAB;
      aw_valid <= 1'b0;
      w_valid  <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      aw_addr  <= '0;
      w_data   <= '0;
      ar_addr  <= '0;
      hold     <= '0;
      err      <= 1'b0;
      tx_count <= '0;
`ifdef NASTI_UART_PRINTER_POLL_EN
      ar_valid <= 1'b0;
      poll_cnt <= '0;
`endif
    end else begin
      state    <= state_n;
      src      <= src_n;
      aw_valid <= aw_valid_n;
      w_valid  <= w_valid_n;
      aw_done  <= aw_done_n;
      w_done   <= w_done_n;
      aw_addr  <= aw_addr_n;
      w_data   <= w_data_n;
      ar_addr  <= 3'd5;
      hold     <= hold_n;
      err      <= err_n;
      tx_count <= tx_count_n;
`ifdef NASTI_UART_PRINTER_POLL_EN
      ar_valid <= ar_valid_n;
      poll_cnt <= poll_cnt_n;
`endif
    end
  end

endmodule
